div_seq: RTL and testbench
==========================

# div_seq

Sequential restoring divider: the inverse of the team's pipelined 4-bit multiplier. It takes an 8-bit dividend (a product-width value) and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder. It produces one quotient bit per clock, under a start/busy/done handshake. It sits beside the multiplier in the arithmetic block set, and benches use it to check multiply/divide round trips.

## Interface
- WIDTH_N, default 8: dividend and quotient width.
- WIDTH_D, default 4: divisor and remainder width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled on rising clk.
- a  in  WIDTH_N  dividend; sampled only when start is accepted.
- b  in  WIDTH_D  divisor; sampled only when start is accepted.
- busy  out  1  high while a division is in progress (RUN state).
- done  out  1  one-cycle pulse; q and r are valid from this cycle on.
- q  out  WIDTH_N  quotient; held until the next accepted start completes.
- r  out  WIDTH_D  remainder; held likewise.
- dz  out  1  divide-by-zero flag; present only with DIV_ZERO_FLAG_EN.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: on start=1, latch a and b, clear the partial remainder, set count=WIDTH_N, go to RUN.
  - RUN: one restoring step per clock.
    - Shift the partial remainder left by one bit, bringing in the next dividend bit, MSB first.
    - Trial-subtract b at width WIDTH_D+1.
    - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
    - Decrement count; when it reaches 0, register q and r and go to DONE.
  - DONE: done=1 for this cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- start during RUN is ignored; a and b changes during RUN have no effect.
- Divide by zero (b=0): falls out of the algorithm with no special case. q = all ones, r = a[WIDTH_D-1:0]. Latency is unchanged.
- Partial remainder width: WIDTH_D+1 bits, so the subtraction never overflows.
- Reset, including mid-RUN: state=IDLE, busy=0, done=0, q=0, r=0, dz=0, count=0. The in-flight operation is dropped and no done is produced.

## Timing
- Let start be sampled high at edge t0 while in IDLE or DONE.
  - busy=1 from t0 through t0+N, where N=WIDTH_N.
  - done=1 from t0+N to t0+N+1.
- Latency: N+1 edges from accepting start to the cycle in which done is sampled high (9 for the defaults).
- Throughput: one division per N+1 cycles when start is held high.
- busy and done are never high in the same cycle.
- q and r change only at the RUN→DONE edge.

## Configuration
- DIV_ZERO_FLAG_EN defined: port dz exists.
  - dz is registered at the RUN→DONE edge: 1 if the latched b was 0, else 0.
  - dz holds with q and r.
- DIV_ZERO_FLAG_EN undefined: no dz port and no flag register. q and r behaviour is identical in both builds.

## Structure
- Package div_pkg:
  - state enum: IDLE, RUN, DONE;
  - default widths;
  - count width constant, $clog2(WIDTH_N+1).
- Sub-module div_step (combinational): one restoring step.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
- Top div_seq holds the FSM, counter and registers, and instantiates div_step once.

## Test plan
- a=8'b10001111 (143), b=4'b1011 (11), single start → done at edge t0+9; q=13, r=0; busy high for 8 cycles.
- a=200, b=7 → q=28, r=4. Then a=5, b=9 → q=0, r=5.
- a=255, b=1 → q=255, r=0. Then a=255, b=15 → q=17, r=0.
- a=100, b=0 → q=255, r=4. dz=1 when DIV_ZERO_FLAG_EN is defined. A following a=100, b=10 gives q=10, r=0, dz=0.
- start held high with new operands presented at each DONE cycle (143/11, then 200/7) → done pulses 9 cycles apart with correct results. start pulses and operand changes during RUN → ignored, results unchanged.
- rst asserted asynchronously mid-RUN (cycle 4 of 143/11) → busy, done, q and r go to 0 immediately with no clock. After release, a fresh 200/7 completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider.
//   - state_e     : FSM states (idle, running, result-valid pulse)
//   - default dividend/quotient and divisor/remainder widths
//   - iteration counter width, wide enough to hold WIDTH_N itself
package div_pkg;

  localparam int unsigned WidthNDefault   = 8;
  localparam int unsigned WidthDDefault   = 4;
  localparam int unsigned CntWidthDefault = $clog2(WidthNDefault + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Counter width for an arbitrary dividend width (counts WIDTH_N down to 0).
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_i  [WIDTH_D:0]   partial remainder from the previous step
//   bit_i                next dividend bit (MSB first)
//   div_i  [WIDTH_D-1:0] divisor
//   rem_o  [WIDTH_D:0]   partial remainder after this step
//   q_o                  quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH_D = 4
) (
  input  logic [WIDTH_D:0]   rem_i,
  input  logic               bit_i,
  input  logic [WIDTH_D-1:0] div_i,
  output logic [WIDTH_D:0]   rem_o,
  output logic               q_o
);

  logic [WIDTH_D:0] shifted;
  logic [WIDTH_D:0] diff;

  // The top remainder bit is shifted out every step; it only carries data when
  // the divisor is zero, where the spilled bit is meant to be lost.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_i[WIDTH_D];

  always_comb begin
    shifted = {rem_i[WIDTH_D-1:0], bit_i};
    diff    = shifted - {1'b0, div_i};
    // Non-negative trial difference <=> shifted >= divisor.
    q_o     = (shifted >= {1'b0, div_i});
    rem_o   = q_o ? diff : shifted;
  end

endmodule

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
//   clk, rst (async, active-high)
//   start        : request, accepted in idle or done state
//   a [WIDTH_N]  : dividend, b [WIDTH_D] : divisor (latched on accept)
//   busy         : high while running
//   done         : one-cycle pulse, q/r valid from this cycle on
//   q [WIDTH_N]  : quotient, r [WIDTH_D] : remainder (held until next result)
//   dz           : divide-by-zero flag, only when DIV_ZERO_FLAG_EN is defined
// Divide by zero needs no special case: q = all ones, r = a[WIDTH_D-1:0].
module div_seq import div_pkg::*; #(
  parameter int unsigned WIDTH_N = WidthNDefault,
  parameter int unsigned WIDTH_D = WidthDDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_N-1:0] a,
  input  logic [WIDTH_D-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] q,
  output logic [WIDTH_D-1:0] r
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               dz
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH_N);

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  // Dividend bits are consumed from the top while quotient bits enter at the
  // bottom, so after WIDTH_N steps this register holds the quotient.
  logic [WIDTH_N-1:0] work_q;
  logic [WIDTH_D-1:0] div_q;
  logic [WIDTH_D:0]   rem_q;
  logic [WIDTH_N-1:0] q_q;
  logic [WIDTH_D-1:0] r_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH_D:0]   rem_nxt;
  logic               q_bit;

  div_step #(
    .WIDTH_D (WIDTH_D)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (work_q[WIDTH_N-1]),
    .div_i (div_q),
    .rem_o (rem_nxt),
    .q_o   (q_bit)
  );

`ifdef DIV_ZERO_FLAG_EN
  logic dz_q;
  assign dz = dz_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            work_q  <= a;
            div_q   <= b;
            rem_q   <= '0;
            cnt_q   <= CntW'(WIDTH_N);
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          rem_q  <= rem_nxt;
          work_q <= {work_q[WIDTH_N-2:0], q_bit};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            q_q     <= {work_q[WIDTH_N-2:0], q_bit};
            r_q     <= rem_nxt[WIDTH_D-1:0];
`ifdef DIV_ZERO_FLAG_EN
            dz_q    <= (div_q == '0);
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq (default 8/4 widths).
// Checks dz as well when built with DIV_ZERO_FLAG_EN.
module tb_div_seq;

  localparam int unsigned N = 8;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [D-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] q;
  logic [D-1:0] r;
`ifdef DIV_ZERO_FLAG_EN
  logic         dz;
  logic         exp_dz_held = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] exp_q_held = '0;
  logic [D-1:0] exp_r_held = '0;

  always #5 clk = ~clk;

  div_seq #(
    .WIDTH_N (N),
    .WIDTH_D (D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .dz    (dz)
`endif
  );

  // Reference: plain integer division; a zero divisor yields all-ones quotient
  // and the low divisor-width bits of the dividend as remainder.
  function automatic logic [N-1:0] ref_q(input logic [N-1:0] x, input logic [D-1:0] y);
    if (y == '0) return '1;
    return x / {4'b0, y};
  endfunction

  function automatic logic [D-1:0] ref_r(input logic [N-1:0] x, input logic [D-1:0] y);
    logic [N-1:0] m;
    if (y == '0) return x[D-1:0];
    m = x % {4'b0, y};
    return m[D-1:0];
  endfunction

  // One division: operands and start presented now (at a negedge), then the
  // N running cycles and the done cycle are checked. With hold=1 start stays
  // high at the done cycle so the caller can chain the next operands. With
  // noise=1, start and the operands are scrambled during the run.
  task automatic run_one(input logic [N-1:0] av, input logic [D-1:0] bv, input bit hold,
                         input bit noise, input string tag);
    logic [N-1:0] eq;
    logic [D-1:0] er;
    eq = ref_q(av, bv);
    er = ref_r(av, bv);
    a = av;
    b = bv;
    start = 1'b1;
    for (int k = 0; k <= int'(N); k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < int'(N)) begin
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL %s run cycle %0d: busy=%b done=%b, required busy=1 done=0",
                   tag, k, busy, done);
        end
        n_vec++;
        if (q !== exp_q_held || r !== exp_r_held) begin
          n_err++;
          $display("FAIL %s held result cycle %0d: q=%0d r=%0d, required q=%0d r=%0d",
                   tag, k, q, r, exp_q_held, exp_r_held);
        end
      end else begin
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b1) begin
          n_err++;
          $display("FAIL %s done cycle: busy=%b done=%b, required busy=0 done=1",
                   tag, busy, done);
        end
        n_vec++;
        if (q !== eq || r !== er) begin
          n_err++;
          $display("FAIL %s result %0d/%0d: q=%0d r=%0d, required q=%0d r=%0d",
                   tag, av, bv, q, r, eq, er);
        end
        exp_q_held = eq;
        exp_r_held = er;
`ifdef DIV_ZERO_FLAG_EN
        n_vec++;
        if (dz !== (bv == '0)) begin
          n_err++;
          $display("FAIL %s dz: dz=%b, required %b", tag, dz, (bv == '0));
        end
        exp_dz_held = (bv == '0);
`endif
      end
      if (!hold) start = (noise && k < int'(N)) ? 1'($urandom % 2) : 1'b0;
      if (noise && k < int'(N)) begin
        a = N'($urandom);
        b = D'($urandom);
      end
    end
  endtask

  // One idle cycle after a done: pulse must be gone, results held.
  task automatic idle_cycle(input string tag);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== exp_q_held || r !== exp_r_held) begin
      n_err++;
      $display("FAIL %s idle: busy=%b done=%b q=%0d r=%0d, required 0 0 %0d %0d",
               tag, busy, done, q, r, exp_q_held, exp_r_held);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== '0 || r !== '0) begin
      n_err++;
      $display("FAIL reset state: busy=%b done=%b q=%0d r=%0d, required all 0",
               busy, done, q, r);
    end
`ifdef DIV_ZERO_FLAG_EN
    n_vec++;
    if (dz !== 1'b0) begin
      n_err++;
      $display("FAIL reset dz: dz=%b, required 0", dz);
    end
`endif
    rst = 1'b0;
    idle_cycle("post_reset");
  endtask

  task automatic test_directed();
    run_one(8'd143, 4'd11, 1'b0, 1'b0, "d143_11"); idle_cycle("d143_11");
    run_one(8'd200, 4'd7,  1'b0, 1'b0, "d200_7");  idle_cycle("d200_7");
    run_one(8'd5,   4'd9,  1'b0, 1'b0, "d5_9");    idle_cycle("d5_9");
    run_one(8'd255, 4'd1,  1'b0, 1'b0, "d255_1");  idle_cycle("d255_1");
    run_one(8'd255, 4'd15, 1'b0, 1'b0, "d255_15"); idle_cycle("d255_15");
  endtask

  task automatic test_div_zero();
    run_one(8'd100, 4'd0,  1'b0, 1'b0, "dz100_0");  idle_cycle("dz100_0");
    run_one(8'd100, 4'd10, 1'b0, 1'b0, "dz100_10"); idle_cycle("dz100_10");
  endtask

  task automatic test_back_to_back();
    run_one(8'd143, 4'd11, 1'b1, 1'b0, "b2b_143_11");
    run_one(8'd200, 4'd7,  1'b1, 1'b0, "b2b_200_7");
    for (int i = 0; i < 4; i++) run_one(N'($urandom), D'($urandom), 1'b1, 1'b0, "b2b_rand");
    run_one(8'd77, 4'd3, 1'b0, 1'b0, "b2b_last");
    idle_cycle("b2b_last");
  endtask

  task automatic test_ignore_during_run();
    run_one(8'd143, 4'd11, 1'b0, 1'b1, "noise_143_11"); idle_cycle("noise_143_11");
    run_one(8'd200, 4'd7,  1'b0, 1'b1, "noise_200_7");  idle_cycle("noise_200_7");
    for (int i = 0; i < 4; i++) begin
      run_one(N'($urandom), D'($urandom), 1'b0, 1'b1, "noise_rand");
      idle_cycle("noise_rand");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [D-1:0] bv;
      bv = (i % 7 == 0) ? '0 : D'($urandom);
      run_one(N'($urandom), bv, 1'b0, 1'b0, "rand");
      if ($urandom % 2 == 1) idle_cycle("rand");
    end
    idle_cycle("rand_end");
  endtask

  task automatic test_async_reset();
    run_one(8'd255, 4'd15, 1'b0, 1'b0, "pre_rst"); // leaves a non-zero result
    idle_cycle("pre_rst");
    a = 8'd143;
    b = 4'd11;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== '0 || r !== '0) begin
      n_err++;
      $display("FAIL async reset: busy=%b done=%b q=%0d r=%0d, required all 0",
               busy, done, q, r);
    end
`ifdef DIV_ZERO_FLAG_EN
    n_vec++;
    if (dz !== 1'b0) begin
      n_err++;
      $display("FAIL async reset dz: dz=%b, required 0", dz);
    end
    exp_dz_held = 1'b0;
`endif
    exp_q_held = '0;
    exp_r_held = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL dropped op cycle %0d: busy=%b done=%b, required 0 0", k, busy, done);
      end
    end
    run_one(8'd200, 4'd7, 1'b0, 1'b0, "post_rst_200_7");
    idle_cycle("post_rst_200_7");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_ignore_during_run();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
